// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer/counter.
// Holds the FSM state encoding, the register offsets decoded from addr[3:2],
// the CTRL bit positions, the mode codes and the base addresses of the two
// timer instances seen by the system bridge.
package tc_pkg;

  // Countdown sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  // Word offsets within one timer's 16-byte window (addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL register layout
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Mode codes held in CTRL[2:1]; codes 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Byte base addresses of the two system instances
  localparam logic [31:0] TC1_BASE = 32'h0000_7f00;
  localparam logic [31:0] TC2_BASE = 32'h0000_7f10;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with interrupt request.
// The CPU programs PRESET and CTRL; once enabled, the timer loads PRESET into
// COUNT, counts down to zero and raises an interrupt flag. One-shot mode
// clears EN on expiry and leaves the flag pending until software writes
// CTRL or PRESET; auto-reload mode drops the flag after one cycle and
// restarts the countdown.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset, clears every register
//   addr   - word address from the bridge; only addr[3:2] is decoded
//   we     - write strobe, sampled at the rising clock edge
//   din    - write data
//   dout   - read data, combinational from addr[3:2]
//   irq    - interrupt request, CTRL.IM gated with the pending flag
module timer_counter
  import tc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [DATA_W-1:0]  preset_q, preset_d;
  logic [DATA_W-1:0]  count_q, count_d;
  logic               flag_q, flag_d;

  logic [1:0] mode;
  logic       unused_addr_bits;

  assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // The device is already selected by the bridge, so the upper address
  // bits carry no information here.
  assign unused_addr_bits = ^addr[31:4];

  // All state lives in one register bank so the whole device resets together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state logic: the countdown sequencer is evaluated first and the CPU
  // write is applied last, so a software write to CTRL overrides the
  // sequencer's EN clear and a CTRL/PRESET write clears the flag even on the
  // cycle the countdown expires.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        // Disabling pauses into IDLE; re-enabling reloads rather than resumes.
        // Expiry at COUNT<=1 keeps COUNT from ever wrapping below zero.
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q > DATA_W'(1)) begin
          count_d = count_q - DATA_W'(1);
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          flag_d = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (we) begin
      case (addr[3:2])
        OFF_CTRL: begin
          ctrl_d = din[CTRL_W-1:0];
          flag_d = 1'b0;
        end
        OFF_PRESET: begin
          preset_d = din;
          flag_d   = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Read mux; unused CTRL bits and the spare offset read as zero.
  always_comb begin
    dout = '0;
    case (addr[3:2])
      OFF_CTRL:   dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: dout = preset_q;
      OFF_COUNT:  dout = count_q;
      default:    dout = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (instance at TC1_BASE).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_timer_counter;
  import tc_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks;
  int failures;

  timer_counter #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word address of a register inside the TC1 window
  function automatic logic [31:2] regAddr(input logic [1:0] off);
    logic [31:0] byteAddr;
    byteAddr = TC1_BASE + {28'd0, off, 2'b00};
    return byteAddr[31:2];
  endfunction

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register write; the write takes effect at the edge inside this task
  task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
    addr = regAddr(off);
    din  = data;
    we   = 1'b1;
    tick(1);
    we   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag, input logic [1:0] off, input logic [31:0] expected);
    addr = regAddr(off);
    #1;
    checkOutput(tag, dout, expected);
  endtask

  task automatic checkIrq(input string tag, input logic expected);
    checkOutput(tag, {31'd0, irq}, {31'd0, expected});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    we       = 1'b0;
    din      = '0;
    addr     = regAddr(OFF_CTRL);

    // Power-on reset
    tick(2);
    reset = 1'b0;
    tick(1);
    checkRead("rst_ctrl", OFF_CTRL, 32'h0);
    checkRead("rst_preset", OFF_PRESET, 32'h0);
    checkRead("rst_count", OFF_COUNT, 32'h0);
    checkIrq("rst_irq", 1'b0);

    // One-shot, PRESET=5: COUNT 5..0 from e0+2, irq at e0+7, EN cleared after
    applyStimulus(OFF_PRESET, 32'd5);
    applyStimulus(OFF_CTRL, 32'h9);
    tick(1);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checkRead($sformatf("os_count_%0d", k), OFF_COUNT, 32'(5 - k));
      checkIrq($sformatf("os_irq_%0d", k), k == 5);
    end
    tick(1);
    checkRead("os_ctrl_en_cleared", OFF_CTRL, 32'h8);
    checkIrq("os_irq_held", 1'b1);
    tick(3);
    checkIrq("os_irq_still_held", 1'b1);
    applyStimulus(OFF_CTRL, 32'h8);
    checkIrq("os_irq_cleared_by_ctrl", 1'b0);

    // Auto-reload, PRESET=3: one-cycle irq at e0+5, e0+11, e0+17
    applyStimulus(OFF_PRESET, 32'd3);
    applyStimulus(OFF_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      checkIrq($sformatf("ar_irq_%0d", k), (k >= 5) && (((k - 5) % 6) == 0));
    end
    applyStimulus(OFF_CTRL, 32'h0);
    tick(4);

    // IM=0: flag sets internally but irq never rises
    applyStimulus(OFF_PRESET, 32'd2);
    applyStimulus(OFF_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      checkIrq($sformatf("im0_irq_%0d", k), 1'b0);
    end
    checkRead("im0_ctrl_en_cleared", OFF_CTRL, 32'h0);
    checkRead("im0_count", OFF_COUNT, 32'h0);
    applyStimulus(OFF_CTRL, 32'h8);
    checkIrq("im0_irq_after_ctrl", 1'b0);
    checkRead("im0_ctrl_readback", OFF_CTRL, 32'h8);

    // Pause at COUNT=6, then re-enable reloads; PRESET change mid-count ignored
    applyStimulus(OFF_PRESET, 32'd10);
    applyStimulus(OFF_CTRL, 32'h1);
    tick(5);
    checkRead("pause_count_7", OFF_COUNT, 32'd7);
    applyStimulus(OFF_CTRL, 32'h0);
    checkRead("pause_count_6", OFF_COUNT, 32'd6);
    tick(4);
    checkRead("pause_hold", OFF_COUNT, 32'd6);
    applyStimulus(OFF_CTRL, 32'h1);
    tick(2);
    checkRead("pause_reload", OFF_COUNT, 32'd10);
    applyStimulus(OFF_PRESET, 32'd20);
    checkRead("preset_midcount_9", OFF_COUNT, 32'd9);
    tick(1);
    checkRead("preset_midcount_8", OFF_COUNT, 32'd8);
    applyStimulus(OFF_CTRL, 32'h0);
    tick(2);

    // PRESET=0 fires like PRESET=1; COUNT and spare offset ignore writes
    applyStimulus(OFF_PRESET, 32'd0);
    applyStimulus(OFF_CTRL, 32'h9);
    tick(1);
    checkIrq("p0_irq_e1", 1'b0);
    tick(1);
    checkRead("p0_count", OFF_COUNT, 32'd0);
    checkIrq("p0_irq_e2", 1'b0);
    tick(1);
    checkIrq("p0_irq_e3", 1'b1);
    tick(1);
    applyStimulus(OFF_COUNT, 32'h55);
    checkRead("ro_count", OFF_COUNT, 32'd0);
    checkIrq("ro_irq_kept", 1'b1);
    applyStimulus(2'd3, 32'hFFFF_FFFF);
    checkRead("spare_reads_0", 2'd3, 32'h0);
    checkRead("spare_ctrl", OFF_CTRL, 32'h8);
    checkRead("spare_preset", OFF_PRESET, 32'h0);
    applyStimulus(OFF_CTRL, 32'h8);

    // Write clear beats flag set on the expiry edge
    applyStimulus(OFF_PRESET, 32'd2);
    applyStimulus(OFF_CTRL, 32'h9);
    tick(3);
    applyStimulus(OFF_PRESET, 32'd2);
    checkIrq("col_flag_irq", 1'b0);
    tick(1);
    checkRead("col_flag_ctrl", OFF_CTRL, 32'h8);
    checkIrq("col_flag_irq_after", 1'b0);

    // CPU CTRL write beats the one-shot EN clear in INT
    applyStimulus(OFF_PRESET, 32'd1);
    applyStimulus(OFF_CTRL, 32'h9);
    tick(3);
    checkIrq("col_en_irq_set", 1'b1);
    applyStimulus(OFF_CTRL, 32'h9);
    checkRead("col_en_ctrl", OFF_CTRL, 32'h9);
    checkIrq("col_en_irq_cleared", 1'b0);
    tick(3);
    checkIrq("col_en_refire", 1'b1);

    // Async reset in INT: irq drops with no clock edge
    reset = 1'b1;
    #1;
    checkIrq("ar_int_irq", 1'b0);
    checkRead("ar_int_ctrl", OFF_CTRL, 32'h0);
    checkRead("ar_int_preset", OFF_PRESET, 32'h0);
    reset = 1'b0;
    tick(1);

    // Async reset mid-count
    applyStimulus(OFF_PRESET, 32'd9);
    applyStimulus(OFF_CTRL, 32'h1);
    tick(4);
    checkRead("ar_cnt_before", OFF_COUNT, 32'd7);
    reset = 1'b1;
    #1;
    checkRead("ar_cnt_count", OFF_COUNT, 32'h0);
    checkRead("ar_cnt_ctrl", OFF_CTRL, 32'h0);
    checkRead("ar_cnt_preset", OFF_PRESET, 32'h0);
    reset = 1'b0;
    tick(3);
    checkRead("ar_cnt_stays_idle", OFF_COUNT, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
